// File: rtl/fifo_pkg.sv
// Shared types and helpers for the narrow/wide width-converting FIFO.
package fifo_pkg;

    typedef enum logic {
        NTO1   = 1'b0,
        ONETON = 1'b1
    } fifo_mode_e;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_unit_ram.sv
// Narrow-unit storage with a WU-unit write port and an RU-unit combinational read port.
// Unit k of each port maps to address (ptr + k) mod CAP, so wide accesses wrap seamlessly.
module fifo_unit_ram
    import fifo_pkg::*;
#(
    parameter int DSIZE = 4,
    parameter int CAP   = 32,
    parameter int WU    = 1,
    parameter int RU    = 2,
    localparam int AW   = clog2(CAP)
) (
    input  logic                  clk,
    input  logic                  wr_en_i,
    input  logic [AW-1:0]         wr_addr_i,
    input  logic [WU*DSIZE-1:0]   wr_units_i,
    input  logic [AW-1:0]         rd_addr_i,
    output logic [RU*DSIZE-1:0]   rd_units_o
);

    logic [DSIZE-1:0] mem_q [CAP];

    // Contents need no reset: pointers and occupancy decide what is readable.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int k = 0; k < WU; k++) begin
                mem_q[wr_addr_i + AW'(k)] <= wr_units_i[k*DSIZE +: DSIZE];
            end
        end
    end

    always_comb begin
        rd_units_o = '0;
        for (int k = 0; k < RU; k++) begin
            rd_units_o[k*DSIZE +: DSIZE] = mem_q[rd_addr_i + AW'(k)];
        end
    end

endmodule

// File: rtl/fifo_sync_nconv.sv
// Single-clock FIFO converting between narrow (DSIZE) and wide (DSIZE*NSIZE) words.
// Occupancy is tracked in narrow units; all flags derive from the registered count.
module fifo_sync_nconv
    import fifo_pkg::*;
#(
    parameter int          DSIZE     = 4,
    parameter int          NSIZE     = 2,
    parameter int          DEPTH     = 16,
    parameter fifo_mode_e  MODE      = NTO1,
    parameter int          ALMOST    = 2,
    parameter logic [63:0] DEF_VALUE = 64'd0,
    parameter bit          LSB_FIRST = 1'b1,
    localparam int WU  = (MODE == NTO1) ? 1 : NSIZE,
    localparam int RU  = (MODE == NTO1) ? NSIZE : 1,
    localparam int WW  = DSIZE * WU,
    localparam int RW  = DSIZE * RU,
    localparam int CAP = DEPTH * NSIZE,
    localparam int CW  = clog2(CAP) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          wr_en,
    input  logic [WW-1:0] wr_data,
    output logic [CW-1:0] wr_count,
    output logic          wr_full,
    output logic          wr_almost_full,
    output logic          wr_overflow,
    input  logic          rd_en,
    output logic [RW-1:0] rd_data,
    output logic          rd_vld,
    output logic [CW-1:0] rd_count,
    output logic          rd_empty,
    output logic          rd_almost_empty,
    output logic          rd_underflow
);

    localparam int AW  = CW - 1;
    localparam int WSH = clog2(WU);
    localparam int RSH = clog2(RU);
    localparam logic [CW-1:0] CAP_C    = CW'(CAP);
    localparam logic [CW-1:0] WU_C     = CW'(WU);
    localparam logic [CW-1:0] RU_C     = CW'(RU);
    localparam logic [CW-1:0] ALMOST_C = CW'(ALMOST);
    localparam logic [RW-1:0] DEF_C    = RW'(DEF_VALUE);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] occ_q, occ_d;
    logic [RW-1:0] rd_data_q, rd_data_d;
    logic          rd_vld_q, rd_vld_d;
    logic          wr_ovf_q, wr_ovf_d;
    logic          rd_unf_q, rd_unf_d;

    logic [CW-1:0] free_units;
    logic          wacc;
    logic          racc;
    logic [WW-1:0] wr_units;
    logic [RW-1:0] rd_units;
    logic [RW-1:0] rd_word;

    assign free_units = CAP_C - occ_q;
    assign wr_full    = free_units < WU_C;
    assign rd_empty   = occ_q < RU_C;
    assign wacc       = wr_en & ~wr_full & ~flush;
    assign racc       = rd_en & ~rd_empty & ~flush;

    // Unit 0 of the storage ports is always the earliest unit in arrival order.
    always_comb begin
        wr_units = '0;
        for (int k = 0; k < WU; k++) begin
            wr_units[k*DSIZE +: DSIZE] = LSB_FIRST ? wr_data[k*DSIZE +: DSIZE]
                                                   : wr_data[(WU-1-k)*DSIZE +: DSIZE];
        end
    end

    always_comb begin
        rd_word = '0;
        for (int k = 0; k < RU; k++) begin
            if (LSB_FIRST) begin
                rd_word[k*DSIZE +: DSIZE] = rd_units[k*DSIZE +: DSIZE];
            end else begin
                rd_word[(RU-1-k)*DSIZE +: DSIZE] = rd_units[k*DSIZE +: DSIZE];
            end
        end
    end

    fifo_unit_ram #(
        .DSIZE (DSIZE),
        .CAP   (CAP),
        .WU    (WU),
        .RU    (RU)
    ) u_ram (
        .clk        (clk),
        .wr_en_i    (wacc),
        .wr_addr_i  (wptr_q),
        .wr_units_i (wr_units),
        .rd_addr_i  (rptr_q),
        .rd_units_o (rd_units)
    );

    always_comb begin
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        occ_d     = occ_q;
        rd_data_d = rd_data_q;
        rd_vld_d  = 1'b0;
        wr_ovf_d  = wr_en & wr_full & ~flush;
        rd_unf_d  = rd_en & rd_empty & ~flush;
        if (flush) begin
            wptr_d    = '0;
            rptr_d    = '0;
            occ_d     = '0;
            rd_data_d = DEF_C;
        end else begin
            if (wacc) begin
                wptr_d = wptr_q + AW'(WU);
            end
            if (racc) begin
                rptr_d    = rptr_q + AW'(RU);
                rd_data_d = rd_word;
                rd_vld_d  = 1'b1;
            end
            occ_d = occ_q + (wacc ? WU_C : '0) - (racc ? RU_C : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q    <= '0;
            rptr_q    <= '0;
            occ_q     <= '0;
            rd_data_q <= DEF_C;
            rd_vld_q  <= 1'b0;
            wr_ovf_q  <= 1'b0;
            rd_unf_q  <= 1'b0;
        end else begin
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            occ_q     <= occ_d;
            rd_data_q <= rd_data_d;
            rd_vld_q  <= rd_vld_d;
            wr_ovf_q  <= wr_ovf_d;
            rd_unf_q  <= rd_unf_d;
        end
    end

    assign wr_count        = occ_q >> WSH;
    assign rd_count        = occ_q >> RSH;
    assign wr_almost_full  = (free_units >> WSH) <= ALMOST_C;
    assign rd_almost_empty = rd_count <= ALMOST_C;
    assign rd_data         = rd_data_q;
    assign rd_vld          = rd_vld_q;
    assign wr_overflow     = wr_ovf_q;
    assign rd_underflow    = rd_unf_q;

endmodule

// File: tb/tb_fifo_sync_nconv.sv
// Bench for fifo_sync_nconv: an NTO1 instance plus two ONETON instances (LSB/MSB first).
module tb_fifo_sync_nconv;
    import fifo_pkg::*;

    int tests_run = 0;
    int tests_failed = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- NTO1 instance ----------------
    logic       n_flush, n_wr_en, n_rd_en;
    logic [3:0] n_wr_data;
    logic [5:0] n_wr_count, n_rd_count;
    logic       n_wr_full, n_wr_af, n_wr_ovf, n_rd_vld, n_rd_empty, n_rd_ae, n_rd_unf;
    logic [7:0] n_rd_data;

    fifo_sync_nconv #(.MODE(NTO1)) dut_n (
        .clk(clk), .rst_n(rst_n), .flush(n_flush),
        .wr_en(n_wr_en), .wr_data(n_wr_data), .wr_count(n_wr_count),
        .wr_full(n_wr_full), .wr_almost_full(n_wr_af), .wr_overflow(n_wr_ovf),
        .rd_en(n_rd_en), .rd_data(n_rd_data), .rd_vld(n_rd_vld), .rd_count(n_rd_count),
        .rd_empty(n_rd_empty), .rd_almost_empty(n_rd_ae), .rd_underflow(n_rd_unf)
    );

    // ---------------- ONETON instances (shared inputs) ----------------
    logic       o_flush, o_wr_en, o_rd_en;
    logic [7:0] o_wr_data;
    logic [5:0] o_wr_count, o_rd_count, m_wr_count, m_rd_count;
    logic       o_wr_full, o_wr_af, o_wr_ovf, o_rd_vld, o_rd_empty, o_rd_ae, o_rd_unf;
    logic       m_wr_full, m_wr_af, m_wr_ovf, m_rd_vld, m_rd_empty, m_rd_ae, m_rd_unf;
    logic [3:0] o_rd_data, m_rd_data;

    fifo_sync_nconv #(.MODE(ONETON), .LSB_FIRST(1'b1)) dut_o (
        .clk(clk), .rst_n(rst_n), .flush(o_flush),
        .wr_en(o_wr_en), .wr_data(o_wr_data), .wr_count(o_wr_count),
        .wr_full(o_wr_full), .wr_almost_full(o_wr_af), .wr_overflow(o_wr_ovf),
        .rd_en(o_rd_en), .rd_data(o_rd_data), .rd_vld(o_rd_vld), .rd_count(o_rd_count),
        .rd_empty(o_rd_empty), .rd_almost_empty(o_rd_ae), .rd_underflow(o_rd_unf)
    );

    fifo_sync_nconv #(.MODE(ONETON), .LSB_FIRST(1'b0)) dut_m (
        .clk(clk), .rst_n(rst_n), .flush(o_flush),
        .wr_en(o_wr_en), .wr_data(o_wr_data), .wr_count(m_wr_count),
        .wr_full(m_wr_full), .wr_almost_full(m_wr_af), .wr_overflow(m_wr_ovf),
        .rd_en(o_rd_en), .rd_data(m_rd_data), .rd_vld(m_rd_vld), .rd_count(m_rd_count),
        .rd_empty(m_rd_empty), .rd_almost_empty(m_rd_ae), .rd_underflow(m_rd_unf)
    );

    // ---------------- scoreboard / model ----------------
    logic [7:0] exp_q[$];
    logic [3:0] o_exp_q[$];
    logic [3:0] m_exp_q[$];
    logic [3:0] half_unit;
    bit         half_valid;
    logic [7:0] n_last_data;

    function automatic int n_occ();
        return 2 * exp_q.size() + (half_valid ? 1 : 0);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        o_exp_q.delete();
        m_exp_q.delete();
        half_valid  = 1'b0;
        half_unit   = 4'h0;
        n_last_data = 8'h00;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        n_flush = 0; n_wr_en = 0; n_rd_en = 0; n_wr_data = 4'h0;
        o_flush = 0; o_wr_en = 0; o_rd_en = 0; o_wr_data = 8'h00;
        model_clear();
        #7;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // One NTO1 cycle: judges acceptance on pre-cycle occupancy, updates the model,
    // returns what the DUT should show after the edge.
    task automatic n_drive(input bit we, input logic [3:0] wd, input bit re,
                           output bit exp_vld, output logic [7:0] exp_data,
                           output bit exp_ovf, output bit exp_unf);
        bit w_ok, r_ok;
        w_ok = we && (n_occ() < 32);
        r_ok = re && (exp_q.size() > 0);
        exp_ovf = we && !w_ok;
        exp_unf = re && !r_ok;
        exp_vld = r_ok;
        if (r_ok) n_last_data = exp_q.pop_front();
        exp_data = n_last_data;
        if (w_ok) begin
            if (half_valid) begin
                exp_q.push_back({wd, half_unit});
                half_valid = 1'b0;
            end else begin
                half_unit  = wd;
                half_valid = 1'b1;
            end
        end
        n_wr_en = we; n_wr_data = wd; n_rd_en = re;
        @(posedge clk);
        #1;
        n_wr_en = 1'b0; n_rd_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        tests_run++;
        if ({n_rd_vld, n_wr_ovf, n_rd_unf, n_rd_empty, n_rd_ae, n_wr_full, n_wr_af} !== 7'b0001100) begin
            tests_failed++;
            $display("FAIL reset_flags got %b exp 0001100",
                     {n_rd_vld, n_wr_ovf, n_rd_unf, n_rd_empty, n_rd_ae, n_wr_full, n_wr_af});
        end
        tests_run++;
        if ({n_wr_count, n_rd_count, n_rd_data} !== 20'h0) begin
            tests_failed++;
            $display("FAIL reset_counts_data got wc=%0d rc=%0d rd=%h exp 0 0 00", n_wr_count, n_rd_count, n_rd_data);
        end
        tests_run++;
        if ({o_rd_empty, m_rd_empty, o_wr_full, o_rd_vld} !== 4'b1100) begin
            tests_failed++;
            $display("FAIL reset_oneton got %b exp 1100", {o_rd_empty, m_rd_empty, o_wr_full, o_rd_vld});
        end
    endtask

    task automatic test_basic();
        bit ev, eo, eu;
        logic [7:0] ed;
        logic [3:0] vals [4];
        vals = '{4'h1, 4'h2, 4'h3, 4'h4};
        apply_reset();
        for (int i = 0; i < 4; i++) n_drive(1'b1, vals[i], 1'b0, ev, ed, eo, eu);
        tests_run++;
        if (n_rd_count !== 6'(exp_q.size()) || n_wr_count !== 6'(n_occ())) begin
            tests_failed++;
            $display("FAIL basic_counts got rc=%0d wc=%0d exp rc=%0d wc=%0d", n_rd_count, n_wr_count, exp_q.size(), n_occ());
        end
        for (int i = 0; i < 2; i++) begin
            n_drive(1'b0, 4'h0, 1'b1, ev, ed, eo, eu);
            tests_run++;
            if (n_rd_vld !== ev || n_rd_data !== ed) begin
                tests_failed++;
                $display("FAIL basic_read%0d got vld=%b data=%h exp vld=%b data=%h", i, n_rd_vld, n_rd_data, ev, ed);
            end
        end
        tests_run++;
        if (n_rd_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_empty got %b exp 1", n_rd_empty);
        end
    endtask

    task automatic test_underflow();
        bit ev, eo, eu;
        logic [7:0] ed;
        apply_reset();
        n_drive(1'b1, 4'h9, 1'b0, ev, ed, eo, eu);
        tests_run++;
        if (n_rd_empty !== 1'b1 || n_rd_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL partial_word got empty=%b rc=%0d exp empty=1 rc=0", n_rd_empty, n_rd_count);
        end
        n_drive(1'b0, 4'h0, 1'b1, ev, ed, eo, eu);
        tests_run++;
        if (n_rd_unf !== eu || n_rd_vld !== ev || n_rd_data !== ed) begin
            tests_failed++;
            $display("FAIL underflow got unf=%b vld=%b data=%h exp unf=%b vld=%b data=%h",
                     n_rd_unf, n_rd_vld, n_rd_data, eu, ev, ed);
        end
    endtask

    task automatic test_fill();
        bit ev, eo, eu;
        logic [7:0] ed;
        apply_reset();
        for (int i = 1; i <= 32; i++) begin
            n_drive(1'b1, 4'($urandom_range(0, 15)), 1'b0, ev, ed, eo, eu);
            tests_run++;
            if (n_wr_af !== (i >= 30) || n_wr_full !== (i >= 32) || n_wr_ovf !== 1'b0) begin
                tests_failed++;
                $display("FAIL fill_flags write %0d got af=%b full=%b ovf=%b exp af=%b full=%b ovf=0",
                         i, n_wr_af, n_wr_full, n_wr_ovf, (i >= 30), (i >= 32));
            end
        end
        n_drive(1'b1, 4'hE, 1'b0, ev, ed, eo, eu);
        tests_run++;
        if (n_wr_ovf !== eo || n_wr_count !== 6'(n_occ())) begin
            tests_failed++;
            $display("FAIL overflow got ovf=%b wc=%0d exp ovf=%b wc=%0d", n_wr_ovf, n_wr_count, eo, n_occ());
        end
        n_drive(1'b1, 4'hD, 1'b1, ev, ed, eo, eu);
        tests_run++;
        if (n_rd_vld !== ev || n_rd_data !== ed || n_wr_ovf !== eo || n_wr_count !== 6'(n_occ())) begin
            tests_failed++;
            $display("FAIL full_rw got vld=%b data=%h ovf=%b wc=%0d exp vld=%b data=%h ovf=%b wc=%0d",
                     n_rd_vld, n_rd_data, n_wr_ovf, n_wr_count, ev, ed, eo, n_occ());
        end
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            n_drive(1'b0, 4'h0, 1'b1, ev, ed, eo, eu);
            tests_run++;
            if (n_rd_vld !== ev || n_rd_data !== ed) begin
                tests_failed++;
                $display("FAIL drain_read%0d got vld=%b data=%h exp vld=%b data=%h", i, n_rd_vld, n_rd_data, ev, ed);
            end
        end
        tests_run++;
        if (n_rd_empty !== 1'b1 || n_rd_ae !== 1'b1 || n_wr_count !== 6'd0) begin
            tests_failed++;
            $display("FAIL drained got empty=%b ae=%b wc=%0d exp 1 1 0", n_rd_empty, n_rd_ae, n_wr_count);
        end
    endtask

    task automatic test_stream();
        bit ev, eo, eu, we;
        logic [7:0] ed;
        int sent, got, cyc;
        apply_reset();
        sent = 0; got = 0; cyc = 0;
        while ((sent < 100 || exp_q.size() > 0) && cyc < 400) begin
            we = (sent < 100);
            n_drive(we, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ev, ed, eo, eu);
            if (we && !eo) sent++;
            tests_run++;
            if (n_rd_vld !== ev || n_rd_unf !== eu || (ev && n_rd_data !== ed)) begin
                tests_failed++;
                $display("FAIL stream cycle %0d got vld=%b unf=%b data=%h exp vld=%b unf=%b data=%h",
                         cyc, n_rd_vld, n_rd_unf, n_rd_data, ev, eu, ed);
            end
            if (ev) got++;
            cyc++;
        end
        tests_run++;
        if (got !== 50) begin
            tests_failed++;
            $display("FAIL stream_words got %0d exp 50 (cycles %0d)", got, cyc);
        end
    endtask

    task automatic test_reset_mid();
        bit ev, eo, eu;
        logic [7:0] ed;
        apply_reset();
        for (int i = 1; i <= 5; i++) n_drive(1'b1, 4'(i), 1'b0, ev, ed, eo, eu);
        n_wr_en = 1'b1; n_wr_data = 4'hF;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (n_wr_count !== 6'd0 || n_rd_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset got wc=%0d empty=%b exp 0 1", n_wr_count, n_rd_empty);
        end
        model_clear();
        n_wr_en = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_drive(1'b1, 4'h6, 1'b0, ev, ed, eo, eu);
        n_drive(1'b1, 4'h7, 1'b0, ev, ed, eo, eu);
        n_drive(1'b0, 4'h0, 1'b1, ev, ed, eo, eu);
        tests_run++;
        if (n_rd_vld !== ev || n_rd_data !== ed) begin
            tests_failed++;
            $display("FAIL post_reset_read got vld=%b data=%h exp vld=%b data=%h", n_rd_vld, n_rd_data, ev, ed);
        end
    endtask

    task automatic test_flush();
        bit ev, eo, eu;
        logic [7:0] ed;
        for (int i = 0; i < 10; i++) n_drive(1'b1, 4'($urandom_range(0, 15)), 1'b0, ev, ed, eo, eu);
        tests_run++;
        if (n_wr_count !== 6'(n_occ())) begin
            tests_failed++;
            $display("FAIL pre_flush_count got %0d exp %0d", n_wr_count, n_occ());
        end
        n_flush = 1'b1; n_wr_en = 1'b1; n_rd_en = 1'b1;
        @(posedge clk);
        #1;
        n_flush = 1'b0; n_wr_en = 1'b0; n_rd_en = 1'b0;
        model_clear();
        tests_run++;
        if (n_wr_count !== 6'd0 || n_rd_empty !== 1'b1 || n_rd_vld !== 1'b0 || n_rd_data !== 8'h00
            || n_wr_ovf !== 1'b0 || n_rd_unf !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush got wc=%0d empty=%b vld=%b data=%h ovf=%b unf=%b exp 0 1 0 00 0 0",
                     n_wr_count, n_rd_empty, n_rd_vld, n_rd_data, n_wr_ovf, n_rd_unf);
        end
        n_drive(1'b1, 4'hB, 1'b0, ev, ed, eo, eu);
        n_drive(1'b1, 4'hC, 1'b0, ev, ed, eo, eu);
        n_drive(1'b0, 4'h0, 1'b1, ev, ed, eo, eu);
        tests_run++;
        if (n_rd_vld !== ev || n_rd_data !== ed) begin
            tests_failed++;
            $display("FAIL post_flush_read got vld=%b data=%h exp vld=%b data=%h", n_rd_vld, n_rd_data, ev, ed);
        end
    endtask

    task automatic test_oneton();
        logic [7:0] words [2];
        logic [3:0] eo_d, em_d;
        words = '{8'hA5, 8'h3C};
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            o_wr_en = 1'b1; o_wr_data = words[i];
            o_exp_q.push_back(words[i][3:0]);
            o_exp_q.push_back(words[i][7:4]);
            m_exp_q.push_back(words[i][7:4]);
            m_exp_q.push_back(words[i][3:0]);
            @(posedge clk);
            #1;
        end
        o_wr_en = 1'b0;
        tests_run++;
        if (o_rd_count !== 6'(o_exp_q.size()) || o_wr_count !== 6'(o_exp_q.size() / 2)) begin
            tests_failed++;
            $display("FAIL oneton_counts got rc=%0d wc=%0d exp rc=%0d wc=%0d", o_rd_count, o_wr_count,
                     o_exp_q.size(), o_exp_q.size() / 2);
        end
        for (int i = 0; i < 4; i++) begin
            o_rd_en = 1'b1;
            @(posedge clk);
            #1;
            o_rd_en = 1'b0;
            eo_d = o_exp_q.pop_front();
            em_d = m_exp_q.pop_front();
            tests_run++;
            if (o_rd_vld !== 1'b1 || o_rd_data !== eo_d || m_rd_vld !== 1'b1 || m_rd_data !== em_d) begin
                tests_failed++;
                $display("FAIL oneton_read%0d got lsb=%h/%b msb=%h/%b exp lsb=%h msb=%h vld=1",
                         i, o_rd_data, o_rd_vld, m_rd_data, m_rd_vld, eo_d, em_d);
            end
        end
        tests_run++;
        if (o_rd_empty !== 1'b1 || m_rd_empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL oneton_empty got lsb=%b msb=%b exp 1 1", o_rd_empty, m_rd_empty);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underflow();
        test_fill();
        test_stream();
        test_reset_mid();
        test_flush();
        test_oneton();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_sync_nconv.md
FIFO_SYNC_NCONV -- requirements
Module: fifo_sync_nconv

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- DSIZE, 4, narrow unit width in bits.
- NSIZE, 2, width ratio; power of two, 2..8.
- DEPTH, 16, capacity in wide words; power of two.
- MODE, NTO1, NTO1 = narrow write / wide read; ONETON = wide write / narrow read.
- ALMOST, 2, almost-flag threshold in port units.
- DEF_VALUE, 0, rd_data reset and flush value.
- LSB_FIRST, 1, 1 = first narrow unit occupies the lowest bits of the wide word.

REQ-002 Ports, one per line: name, direction, width, meaning. Clock and reset come first.
- clk, in, 1, single clock; all logic is rising-edge.
- rst_n, in, 1, asynchronous active-low reset.
- flush, in, 1, synchronous clear.
- wr_en, in, 1, write request.
- wr_data, in, WW, write word; WW = DSIZE in NTO1, DSIZE*NSIZE in ONETON.
- wr_count, out, CW, stored data in write-port units (floor).
- wr_full, out, 1, a write cannot be accepted.
- wr_almost_full, out, 1, free write slots <= ALMOST.
- wr_overflow, out, 1, one-cycle pulse on a rejected write.
- rd_en, in, 1, read request.
- rd_data, out, RW, read word; RW is the other width from WW.
- rd_vld, out, 1, rd_data valid this cycle.
- rd_count, out, CW, read-port units available.
- rd_empty, out, 1, a read cannot be accepted.
- rd_almost_empty, out, 1, rd_count <= ALMOST.
- rd_underflow, out, 1, one-cycle pulse on a rejected read.

REQ-003 CW SHALL equal clog2(DEPTH*NSIZE)+1.

Function
REQ-004 Storage SHALL be CAP = DEPTH*NSIZE narrow units with write and read unit pointers that wrap modulo CAP.
REQ-005 Occupancy occ (in units) SHALL update each cycle as occ + wacc*WU - racc*RU.
- NTO1: WU=1, RU=NSIZE.
- ONETON: WU=NSIZE, RU=1.
REQ-006 wr_full SHALL be (CAP - occ) < WU, and rd_empty SHALL be occ < RU; both are derived from registered occ only.
REQ-007 A write is accepted (wacc) when wr_en=1 and wr_full=0; otherwise wr_overflow pulses for 1 cycle and the data is dropped.
REQ-008 A read is accepted (racc) when rd_en=1 and rd_empty=0; otherwise rd_underflow pulses, rd_vld stays 0 and rd_data holds.
REQ-009 Simultaneous write and read SHALL each be judged on the pre-cycle flags; a read in the same cycle does not unblock a write at full, and a write does not unblock a read at empty.
REQ-010 Read latency SHALL be 1 cycle: rd_data is registered and rd_vld=1 in the cycle after racc.
REQ-011 Wide words SHALL be assembled from and split into narrow units in arrival order, with the first unit at bits [DSIZE-1:0] when LSB_FIRST=1 and at the top when LSB_FIRST=0.
REQ-012 Derived outputs:
- wr_count = occ/WU.
- rd_count = occ/RU.
- wr_almost_full = ((CAP-occ)/WU) <= ALMOST.
- rd_almost_empty = rd_count <= ALMOST.
REQ-013 In NTO1, a partial word (0 < occ < NSIZE) SHALL stay unreadable: rd_empty=1 and rd_count=0.
REQ-014 flush=1 SHALL clear pointers and occ, set rd_data=DEF_VALUE and rd_vld=0, and ignore wr_en/rd_en that cycle; overflow and underflow pulses are suppressed.
REQ-015 Pointer wrap at CAP-1 to 0 SHALL be seamless, including when a wide access straddles the wrap boundary.

Reset
REQ-016 On rst_n=0 (asynchronous):
- pointers and occ = 0
- rd_data = DEF_VALUE
- rd_vld, wr_overflow, rd_underflow = 0
- rd_empty = 1, rd_almost_empty = 1
- wr_full = 0, wr_almost_full = 0
- wr_count = rd_count = 0
REQ-017 Reset asserted mid-burst SHALL discard all stored data; the first write after release lands at unit 0.

Structure
REQ-018 Package fifo_pkg SHALL hold the mode enum (NTO1, ONETON) and a clog2 helper function.
REQ-019 The narrow-unit storage array with its multi-unit write and read ports SHALL be sub-module fifo_unit_ram; pointer, occupancy and flag logic stay in fifo_sync_nconv.

Verification (DSIZE=4, NSIZE=2, DEPTH=16, ALMOST=2 unless noted)
REQ-020 NTO1: write 1,2,3,4 -> rd_count=2; two reads -> rd_data 8'h21 then 8'h43, each with rd_vld one cycle after rd_en.
REQ-021 NTO1 fill:
- wr_almost_full rises after the 30th write.
- wr_full rises after the 32nd write.
- A 33rd write pulses wr_overflow and leaves occ at 32.
- The simultaneous read+write at full accepts only the read, leaving occ=30.
REQ-022 NTO1 single write then rd_en -> rd_empty=1, rd_underflow pulses, rd_vld=0, rd_data stays 8'h00.
REQ-023 ONETON: write 8'hA5, 8'h3C -> narrow reads 5, A, C, 3; after the last read rd_empty=1. LSB_FIRST=0 gives A, 5, 3, C.
REQ-024 Wrap/continuity: 100 NTO1 units streamed with concurrent reads -> all 50 wide words match the packed sequence.
REQ-025 Reset and flush:
- rst_n low mid-burst, then 2 writes and 1 read -> rd_data = first post-reset pair; no stale data.
- flush at occ=10 -> occ=0 next cycle; rd_empty=1.
